reg_dest_scoreboard: RTL and testbench
======================================

Name: reg_dest_scoreboard

Overview:
- Tracks register-file destinations that are in flight, i.e. issued but not yet written back.
- Consumes the 5-bit write-register address chosen by the destination-select mux at issue and retires it at writeback.
- Answers read-side hazard queries for up to two 5-bit source addresses per issue slot and drives the issue-stage stall.
- Sits between the decode/issue stage and the writeback stage of the pipelined datapath.

Parameters:
MAX_OUTSTANDING, 4, maximum concurrently pending destinations (1..31)
WB_BYPASS, 1, 1 = a source matching the same-cycle writeback does not stall; 0 = it stalls

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
issue_valid  input  1  instruction present at issue
issue_wen  input  1  instruction writes a register
issue_dest  input  5  destination address (from destination mux)
src_a  input  5  first source address
src_a_used  input  1  src_a is read
src_b  input  5  second source address
src_b_used  input  1  src_b is read
wb_valid  input  1  writeback occurring this cycle
wb_dest  input  5  register being written back
flush  input  1  discard all in-flight destinations
stall  output  1  issue must hold (combinational)
issue_fire  output  1  issue accepted this cycle (combinational)
pending  output  32  per-register pending bitmap (registered)
outstanding  output  3  count of set pending bits (registered; width = clog2(MAX_OUTSTANDING+1))
wb_err  output  1  sticky: writeback to a non-pending register (registered)

Behaviour:
- Reset (rst_n low, asynchronous): pending=0, outstanding=0, wb_err=0. Outputs hold these until the first clk edge after deassertion.
- Register 0 is never pending.
  - A source of 0 never hazards.
  - An issue with dest 0 is accepted but sets nothing.
  - A writeback to 0 is ignored and does not set wb_err.
- Hazard terms, all computed from registered pending:
  - raw_a = src_a_used && src_a!=0 && pending[src_a] && !(WB_BYPASS && wb_valid && wb_dest==src_a)
  - raw_b: same form as raw_a, using src_b.
  - waw = issue_wen && issue_dest!=0 && pending[issue_dest]. Never bypassed; the new bit waits for the clear to land.
  - full = (outstanding==MAX_OUTSTANDING) && issue_wen && issue_dest!=0
- Outputs derived from the hazard terms:
  - stall = issue_valid && !flush && (raw_a || raw_b || waw || full)
  - issue_fire = issue_valid && !flush && !stall
- Next-state at clk, highest priority first:
  1. flush: pending=0, outstanding=0. Same-cycle issue and writeback are discarded. wb_err is unchanged.
  2. Otherwise:
     - clear = wb_valid && wb_dest!=0 && pending[wb_dest]. When true, pending[wb_dest] goes to 0.
     - set = issue_fire && issue_wen && issue_dest!=0. When true, pending[issue_dest] goes to 1.
     - set and clear never target the same register in one cycle, because waw blocks it.
     - outstanding += set - clear. Simultaneous set and clear leaves the count unchanged.
  3. wb_valid && wb_dest!=0 && !pending[wb_dest] && !flush: wb_err goes to 1 and stays until reset.
- Latency:
  - An accepted issue is visible in pending and in hazard checks on the next cycle.
  - A writeback clear takes effect next cycle. With WB_BYPASS=1 it also releases dependent sources in the same cycle.
- Invariant: outstanding == popcount(pending) <= MAX_OUTSTANDING at all times. The bench asserts this every cycle.
- Reset mid-operation: all state clears immediately. stall drops in the same cycle unless issue inputs re-hazard against the cleared state.

Test Plan:
- Reset, then issue dest=5 wen=1 -> issue_fire=1. Next cycle pending=0x00000020, outstanding=1.
- With r5 pending, issue src_a=5 used -> stall=1. Apply wb_valid wb_dest=5 in the same cycle:
  - WB_BYPASS=1 -> stall=0, then pending=0.
  - WB_BYPASS=0 -> stall=1 that cycle, 0 the next.
- With r5 pending, issue dest=5 -> stall=1 (waw) even with wb_dest=5 this cycle. Next cycle the issue fires and pending[5]=1, outstanding=1.
- MAX_OUTSTANDING=4:
  - Issue dests 1,2,3,4 -> outstanding=4.
  - Issue dest=6 -> stall=1.
  - Issue dest=0 or wen=0 -> not stalled by full.
  - wb_dest=2 -> next issue dest=6 fires.
- With pending={1,2,3}, assert flush together with issue dest=7 and wb_dest=1 -> next cycle pending=0, outstanding=0, no set of r7.
- wb_dest=9 while not pending -> wb_err=1 next cycle and stays 1. wb_dest=0 -> wb_err unaffected. Drop rst_n mid-sequence -> all outputs 0 immediately.

Source files
------------

// File: rtl/reg_dest_scoreboard.sv
// In-flight destination scoreboard: one pending bit per architectural register.
// Drives the issue stall for RAW, WAW and capacity hazards, and retires bits at writeback.
module reg_dest_scoreboard #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter bit          WB_BYPASS       = 1'b1,
  localparam int unsigned CntW           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  input  logic            issue_wen,
  input  logic [4:0]      issue_dest,
  input  logic [4:0]      src_a,
  input  logic            src_a_used,
  input  logic [4:0]      src_b,
  input  logic            src_b_used,
  input  logic            wb_valid,
  input  logic [4:0]      wb_dest,
  input  logic            flush,
  output logic            stall,
  output logic            issue_fire,
  output logic [31:0]     pending,
  output logic [CntW-1:0] outstanding,
  output logic            wb_err
);

  logic [31:0]     pending_q, pending_d;
  logic [CntW-1:0] outstanding_q, outstanding_d;
  logic            wb_err_q, wb_err_d;

  logic raw_a, raw_b, waw, full;
  logic dest_wr, set, clear, wb_stray;

  always_comb begin
    dest_wr = issue_wen && (issue_dest != 5'd0);
    // The bypass only lifts RAW: a matching writeback makes the source value available now.
    raw_a = src_a_used && (src_a != 5'd0) && pending_q[src_a] &&
            !(WB_BYPASS && wb_valid && (wb_dest == src_a));
    raw_b = src_b_used && (src_b != 5'd0) && pending_q[src_b] &&
            !(WB_BYPASS && wb_valid && (wb_dest == src_b));
    waw   = dest_wr && pending_q[issue_dest];
    full  = (outstanding_q == CntW'(MAX_OUTSTANDING)) && dest_wr;

    stall      = issue_valid && !flush && (raw_a || raw_b || waw || full);
    issue_fire = issue_valid && !flush && !stall;

    set      = issue_fire && dest_wr;
    clear    = wb_valid && (wb_dest != 5'd0) && pending_q[wb_dest];
    wb_stray = wb_valid && (wb_dest != 5'd0) && !pending_q[wb_dest] && !flush;
  end

  always_comb begin
    pending_d     = pending_q;
    outstanding_d = outstanding_q;
    wb_err_d      = wb_err_q || wb_stray;
    if (flush) begin
      pending_d     = '0;
      outstanding_d = '0;
    end else begin
      // waw guarantees set and clear never hit the same register.
      if (clear) pending_d[wb_dest]  = 1'b0;
      if (set)   pending_d[issue_dest] = 1'b1;
      unique case ({set, clear})
        2'b10:   outstanding_d = outstanding_q + CntW'(1);
        2'b01:   outstanding_d = outstanding_q - CntW'(1);
        default: outstanding_d = outstanding_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q     <= '0;
      outstanding_q <= '0;
      wb_err_q      <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      outstanding_q <= outstanding_d;
      wb_err_q      <= wb_err_d;
    end
  end

  assign pending     = pending_q;
  assign outstanding = outstanding_q;
  assign wb_err      = wb_err_q;

endmodule

// File: tb/tb_reg_dest_scoreboard.sv
// Bench for reg_dest_scoreboard: directed vector table, bypass corner sequence,
// randomized traffic against a register-set reference model, and mid-run reset.
module tb_reg_dest_scoreboard;

  localparam int MaxOut = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, issue_wen, src_a_used, src_b_used, wb_valid, flush;
  logic [4:0]  issue_dest, src_a, src_b, wb_dest;
  logic        stall, issue_fire, wb_err;
  logic [31:0] pending;
  logic [2:0]  outstanding;
  logic        stall_nb, issue_fire_nb, wb_err_nb;
  logic [31:0] pending_nb;
  logic [2:0]  outstanding_nb;

  int n_tests = 0;
  int n_fail  = 0;

  bit m_pend[32];
  bit m_err;

  always #5 clk = ~clk;

  reg_dest_scoreboard #(.MAX_OUTSTANDING(MaxOut), .WB_BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_wen(issue_wen),
    .issue_dest(issue_dest), .src_a(src_a), .src_a_used(src_a_used), .src_b(src_b),
    .src_b_used(src_b_used), .wb_valid(wb_valid), .wb_dest(wb_dest), .flush(flush),
    .stall(stall), .issue_fire(issue_fire), .pending(pending), .outstanding(outstanding),
    .wb_err(wb_err)
  );

  reg_dest_scoreboard #(.MAX_OUTSTANDING(MaxOut), .WB_BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_wen(issue_wen),
    .issue_dest(issue_dest), .src_a(src_a), .src_a_used(src_a_used), .src_b(src_b),
    .src_b_used(src_b_used), .wb_valid(wb_valid), .wb_dest(wb_dest), .flush(flush),
    .stall(stall_nb), .issue_fire(issue_fire_nb), .pending(pending_nb),
    .outstanding(outstanding_nb), .wb_err(wb_err_nb)
  );

  typedef struct {
    logic iv; logic wen; logic [4:0] dest; logic [4:0] sa; logic sau;
    logic wbv; logic [4:0] wbd; logic fl;
    logic e_stall; logic e_fire; logic [31:0] e_pend; int e_out; logic e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic iv, logic wen, logic [4:0] dest, logic [4:0] sa, logic sau,
                              logic wbv, logic [4:0] wbd, logic fl, logic e_stall,
                              logic e_fire, logic [31:0] e_pend, int e_out, logic e_err);
    vec_t v;
    v.iv = iv; v.wen = wen; v.dest = dest; v.sa = sa; v.sau = sau;
    v.wbv = wbv; v.wbd = wbd; v.fl = fl;
    v.e_stall = e_stall; v.e_fire = e_fire; v.e_pend = e_pend; v.e_out = e_out; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int r = 0; r < 32; r++) if (m_pend[r]) c++;
    return c;
  endfunction

  function automatic logic [31:0] m_vec();
    logic [31:0] v = '0;
    for (int r = 0; r < 32; r++) v[r] = m_pend[r];
    return v;
  endfunction

  function automatic bit m_hazard(logic [4:0] s, logic used);
    return used && s != 0 && m_pend[s] && !(wb_valid && wb_dest == s);
  endfunction

  task automatic drive(input logic iv, input logic wen, input logic [4:0] dest,
                       input logic [4:0] sa, input logic sau, input logic wbv,
                       input logic [4:0] wbd, input logic fl);
    issue_valid = iv; issue_wen = wen; issue_dest = dest;
    src_a = sa; src_a_used = sau; src_b = 5'd0; src_b_used = 1'b0;
    wb_valid = wbv; wb_dest = wbd; flush = fl;
  endtask

  // Checks comb outputs mid-cycle, advances the model at the edge, then checks state.
  task automatic cycle(output logic s_stall, output logic s_fire);
    bit hz, e_stall, e_fire, wr;
    @(negedge clk);
    wr = issue_wen && issue_dest != 0;
    hz = m_hazard(src_a, src_a_used) || m_hazard(src_b, src_b_used) ||
         (wr && m_pend[issue_dest]) || (wr && m_count() == MaxOut);
    e_stall = issue_valid && !flush && hz;
    e_fire  = issue_valid && !flush && !hz;
    s_stall = stall;
    s_fire  = issue_fire;
    chk("stall", {31'd0, stall}, {31'd0, e_stall});
    chk("issue_fire", {31'd0, issue_fire}, {31'd0, e_fire});
    @(posedge clk);
    if (flush) begin
      for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
    end else begin
      if (wb_valid && wb_dest != 0) begin
        if (m_pend[wb_dest]) m_pend[wb_dest] = 1'b0;
        else m_err = 1'b1;
      end
      if (e_fire && wr) m_pend[issue_dest] = 1'b1;
    end
    #1;
    chk("pending", pending, m_vec());
    chk("outstanding", {29'd0, outstanding}, m_count());
    chk("wb_err", {31'd0, wb_err}, {31'd0, m_err});
    chk("invariant", {31'd0, ($countones(pending) == int'(outstanding)) &&
                             (int'(outstanding) <= MaxOut)}, 32'd1);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
    m_err = 1'b0;
    #1;
    chk("reset_pending", pending, 32'd0);
    chk("reset_outstanding", {29'd0, outstanding}, 32'd0);
    chk("reset_wb_err", {31'd0, wb_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic s_stall, s_fire;

  initial begin
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    do_reset();

    // WB_BYPASS=0 instance must stall on the same-cycle writeback, then release.
    drive(1, 1, 5, 0, 0, 0, 0, 0);
    cycle(s_stall, s_fire);
    drive(1, 0, 0, 5, 1, 1, 5, 0);
    #2;
    chk("nobypass_stall", {31'd0, stall_nb}, 32'd1);
    cycle(s_stall, s_fire);
    chk("bypass_stall", {31'd0, s_stall}, 32'd0);
    drive(1, 0, 0, 5, 1, 0, 0, 0);
    #2;
    chk("nobypass_release", {31'd0, stall_nb}, 32'd0);
    cycle(s_stall, s_fire);
    do_reset();

    //               iv wen dst sa sau wbv wbd fl | stall fire pend out err
    tbl.push_back(mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 1, 32'h20, 1, 0));
    tbl.push_back(mk(1, 0, 0, 5, 1, 1, 5, 0, 0, 1, 32'h00, 0, 0));
    tbl.push_back(mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 1, 32'h20, 1, 0));
    tbl.push_back(mk(1, 1, 5, 0, 0, 1, 5, 0, 1, 0, 32'h00, 0, 0));
    tbl.push_back(mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 1, 32'h20, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 32'h00, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 32'h02, 1, 0));
    tbl.push_back(mk(1, 1, 2, 0, 0, 0, 0, 0, 0, 1, 32'h06, 2, 0));
    tbl.push_back(mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 1, 32'h0E, 3, 0));
    tbl.push_back(mk(1, 1, 4, 0, 0, 0, 0, 0, 0, 1, 32'h1E, 4, 0));
    tbl.push_back(mk(1, 1, 6, 0, 0, 0, 0, 0, 1, 0, 32'h1E, 4, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1E, 4, 0));
    tbl.push_back(mk(1, 0, 6, 0, 0, 0, 0, 0, 0, 1, 32'h1E, 4, 0));
    tbl.push_back(mk(1, 1, 6, 0, 0, 1, 2, 0, 1, 0, 32'h1A, 3, 0));
    tbl.push_back(mk(1, 1, 6, 0, 0, 0, 0, 0, 0, 1, 32'h5A, 4, 0));
    tbl.push_back(mk(1, 1, 7, 0, 0, 1, 1, 1, 0, 0, 32'h00, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h00, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 32'h00, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h00, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h00, 0, 1));

    foreach (tbl[i]) begin
      drive(tbl[i].iv, tbl[i].wen, tbl[i].dest, tbl[i].sa, tbl[i].sau,
            tbl[i].wbv, tbl[i].wbd, tbl[i].fl);
      cycle(s_stall, s_fire);
      chk($sformatf("vec%0d_stall", i), {31'd0, s_stall}, {31'd0, tbl[i].e_stall});
      chk($sformatf("vec%0d_fire", i), {31'd0, s_fire}, {31'd0, tbl[i].e_fire});
      chk($sformatf("vec%0d_pending", i), pending, tbl[i].e_pend);
      chk($sformatf("vec%0d_outstanding", i), {29'd0, outstanding}, tbl[i].e_out);
      chk($sformatf("vec%0d_wb_err", i), {31'd0, wb_err}, {31'd0, tbl[i].e_err});
    end

    do_reset();
    for (int n = 0; n < 3000; n++) begin
      issue_valid = ($urandom_range(0, 3) != 0);
      issue_wen   = ($urandom_range(0, 3) != 0);
      issue_dest  = 5'($urandom_range(0, 7));
      src_a       = 5'($urandom_range(0, 7));
      src_a_used  = $urandom_range(0, 1) != 0;
      src_b       = 5'($urandom_range(0, 7));
      src_b_used  = $urandom_range(0, 1) != 0;
      wb_valid    = $urandom_range(0, 1) != 0;
      wb_dest     = 5'($urandom_range(0, 7));
      flush       = ($urandom_range(0, 63) == 0);
      cycle(s_stall, s_fire);
    end

    // Asynchronous reset while a RAW stall is being held.
    drive(1, 1, 3, 0, 0, 0, 0, 1);
    cycle(s_stall, s_fire);
    drive(1, 1, 3, 0, 0, 0, 0, 0);
    cycle(s_stall, s_fire);
    drive(0, 0, 0, 0, 0, 1, 12, 0);
    cycle(s_stall, s_fire);
    drive(1, 0, 0, 3, 1, 0, 0, 0);
    #2;
    chk("pre_reset_stall", {31'd0, stall}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_pending", pending, 32'd0);
    chk("mid_reset_outstanding", {29'd0, outstanding}, 32'd0);
    chk("mid_reset_wb_err", {31'd0, wb_err}, 32'd0);
    chk("mid_reset_stall", {31'd0, stall}, 32'd0);
    #10;
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
